// File: rtl/wb_ddr3_responder_pkg.sv
// Shared types and helpers for the DDR3-controller stand-in responder.
package wb_ddr3_responder_pkg;

   typedef enum logic [1:0] {INIT, ACTIVE, FLUSH} state_t;

   // Fibonacci LFSR, taps 16,15,13,4 -> bit positions 15,14,12,3
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hD008;

   function automatic int byte_lanes(input int data_width);
      return data_width / 8;
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/wb_ddr3_responder_if.sv
// Pipelined Wishbone B4 bus between an initiator and the DDR3-style responder.
interface wb_ddr3_responder_if
   import wb_ddr3_responder_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_BITS  = 24,
   parameter int AUX_WIDTH  = 4
);
   logic                              i_wb_cyc;
   logic                              i_wb_stb;
   logic                              i_wb_we;
   logic [ADDR_BITS-1:0]              i_wb_addr;
   logic [DATA_WIDTH-1:0]             i_wb_data;
   logic [byte_lanes(DATA_WIDTH)-1:0] i_wb_sel;
   logic [AUX_WIDTH-1:0]              i_aux;
   logic                              o_wb_stall;
   logic                              o_wb_ack;
   logic [DATA_WIDTH-1:0]             o_wb_data;
   logic [AUX_WIDTH-1:0]              o_aux;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel, i_aux,
      input  o_wb_stall, o_wb_ack, o_wb_data, o_aux
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel, i_aux,
      output o_wb_stall, o_wb_ack, o_wb_data, o_aux
   );
endinterface

// File: rtl/wb_resp_delay_line.sv
// Fixed-depth response pipe of {valid, data, aux}; flush drops every in-flight valid.
module wb_resp_delay_line #(
   parameter int LATENCY    = 8,
   parameter int DATA_WIDTH = 128,
   parameter int AUX_WIDTH  = 4
) (
   input  logic                  i_controller_clk,
   input  logic                  i_rst,
   input  logic                  flush,
   input  logic                  in_vld,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [AUX_WIDTH-1:0]  in_aux,
   output logic                  out_vld,
   output logic                  ack_ahead,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [AUX_WIDTH-1:0]  out_aux
);
   logic [LATENCY:1]                 vld_pipe;
   logic [LATENCY:1][DATA_WIDTH-1:0] data_pipe;
   logic [LATENCY:1][AUX_WIDTH-1:0]  aux_pipe;

   always_ff @(posedge i_controller_clk) begin
      if (i_rst) begin
         vld_pipe  <= '0;
         data_pipe <= '0;
         aux_pipe  <= '0;
      end else begin
         vld_pipe  <= flush ? '0 : {vld_pipe[LATENCY-1:1], in_vld};
         data_pipe <= {data_pipe[LATENCY-1:1], in_data};
         aux_pipe  <= {aux_pipe[LATENCY-1:1], in_aux};
      end
   end

   assign out_vld   = vld_pipe[LATENCY];
   // valid that becomes the ack on the next edge; lets stall stay registered
   assign ack_ahead = vld_pipe[LATENCY-1];
   assign out_data  = data_pipe[LATENCY];
   assign out_aux   = aux_pipe[LATENCY];
endmodule

// File: rtl/wb_ddr3_responder.sv
// RAM-backed Wishbone responder mimicking the DDR3 controller user port.
// Optional random stall injection: define WB_RESP_STALL_INJECT_EN.
module wb_ddr3_responder
   import wb_ddr3_responder_pkg::*;
#(
   parameter int DATA_WIDTH      = 128,
   parameter int ADDR_BITS       = 24,
   parameter int AUX_WIDTH       = 4,
   parameter int DEPTH           = 1024,
   parameter int LATENCY         = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int INIT_CYCLES     = 64
) (
   input  logic               i_controller_clk,
   input  logic               i_rst,
   wb_ddr3_responder_if.slave wb,
   output logic               o_calib_done
);
   localparam int NUM_LANES = byte_lanes(DATA_WIDTH);
   localparam int IDX_W     = $clog2(DEPTH);
   localparam int CNT_W     = $clog2(INIT_CYCLES + 1);
   localparam int PEND_W    = $clog2(MAX_OUTSTANDING + 1);

   state_t                  state;
   logic [CNT_W-1:0]        init_cnt;
   logic [PEND_W-1:0]       pend, pend_nx;
   logic                    stall_q, calib_q;
   logic                    accept, flush, ack, ack_ahead, inj_nx;

   logic [IDX_W-1:0]        idx;
   logic [NUM_LANES-1:0][7:0] mem [DEPTH];
   logic [NUM_LANES-1:0][7:0] wr_lanes;
   logic [DATA_WIDTH-1:0]   req_data;
   logic [AUX_WIDTH-1:0]    req_aux;
   logic                    req_vld;
   logic [DATA_WIDTH-1:0]   dl_data;
   logic [AUX_WIDTH-1:0]    dl_aux;
   logic                    unused_addr;

   assign idx         = wb.i_wb_addr[IDX_W-1:0];
   assign unused_addr = ^wb.i_wb_addr[ADDR_BITS-1:IDX_W];
   assign wr_lanes    = wb.i_wb_data;
   assign accept      = wb.i_wb_cyc & wb.i_wb_stb & ~stall_q;
   assign flush       = (state == FLUSH) ||
                        (state == ACTIVE && !wb.i_wb_cyc && pend != '0);
   assign pend_nx     = pend + PEND_W'(accept) - PEND_W'(ack);

`ifdef WB_RESP_STALL_INJECT_EN
   logic [15:0] lfsr, lfsr_nx;
   assign lfsr_nx = (state == ACTIVE) ? lfsr_step(lfsr) : lfsr;
   // stall is registered, so decide on the LFSR value the next cycle will hold
   assign inj_nx  = (lfsr_nx[1:0] == 2'b00);

   always_ff @(posedge i_controller_clk) begin
      if (i_rst) lfsr <= LFSR_SEED;
      else       lfsr <= lfsr_nx;
   end
`else
   assign inj_nx = 1'b0;
`endif

   always_ff @(posedge i_controller_clk) begin
      if (i_rst) begin
         state    <= INIT;
         init_cnt <= '0;
         pend     <= '0;
         stall_q  <= 1'b1;
         calib_q  <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               if (init_cnt == CNT_W'(INIT_CYCLES - 1)) begin
                  state   <= ACTIVE;
                  calib_q <= 1'b1;
                  stall_q <= inj_nx;
               end else begin
                  init_cnt <= init_cnt + CNT_W'(1);
               end
            end
            ACTIVE: begin
               if (flush) begin
                  state   <= FLUSH;
                  pend    <= '0;
                  stall_q <= 1'b1;
               end else begin
                  pend    <= pend_nx;
                  // full but an ack leaves next cycle: keep accepting
                  stall_q <= (pend_nx == PEND_W'(MAX_OUTSTANDING) && !ack_ahead) || inj_nx;
               end
            end
            FLUSH: begin
               state   <= ACTIVE;
               stall_q <= inj_nx;
            end
            default: begin
               state   <= INIT;
               stall_q <= 1'b1;
            end
         endcase
      end
   end

   // RAM: byte-masked write and read sample on the accept edge; contents survive reset
   always_ff @(posedge i_controller_clk) begin
      if (accept) begin
         if (wb.i_wb_we) begin
            for (int b = 0; b < NUM_LANES; b++)
               if (wb.i_wb_sel[b]) mem[idx][b] <= wr_lanes[b];
            req_data <= '0;
         end else begin
            req_data <= mem[idx];
         end
         req_aux <= wb.i_aux;
      end
   end

   always_ff @(posedge i_controller_clk) begin
      if (i_rst) req_vld <= 1'b0;
      else       req_vld <= accept;
   end

   wb_resp_delay_line #(
      .LATENCY    (LATENCY),
      .DATA_WIDTH (DATA_WIDTH),
      .AUX_WIDTH  (AUX_WIDTH)
   ) u_dly (
      .i_controller_clk (i_controller_clk),
      .i_rst            (i_rst),
      .flush            (flush),
      .in_vld           (req_vld),
      .in_data          (req_data),
      .in_aux           (req_aux),
      .out_vld          (ack),
      .ack_ahead        (ack_ahead),
      .out_data         (dl_data),
      .out_aux          (dl_aux)
   );

   assign wb.o_wb_stall = stall_q;
   assign wb.o_wb_ack   = ack;
   assign wb.o_wb_data  = dl_data;
   assign wb.o_aux      = dl_aux;
   assign o_calib_done  = calib_q;
endmodule

// File: doc/wb_ddr3_responder.md
Name: wb_ddr3_responder

Overview:
- Synthesizable pipelined Wishbone B4 responder that mimics the user-side interface of the DDR3 controller: calibration wait, stall, fixed-latency ack, read data and aux echo.
- Backed by an on-chip RAM.
- Lets demo tops and Wishbone initiators (UART bridges, traffic generators) be brought up and verified without a DDR3 device or PHY.
- Sits in place of the controller on the initiator's Wishbone bus.

Parameters:
- DATA_WIDTH, 128, Wishbone data width in bits; must be a multiple of 8.
- ADDR_BITS, 24, Wishbone burst address width.
- AUX_WIDTH, 4, sideband width, echoed on ack.
- DEPTH, 1024, RAM words; power of 2.
- LATENCY, 8, accept-to-ack cycles; must be >= 2.
- MAX_OUTSTANDING, 4, maximum in-flight requests.
- INIT_CYCLES, 64, post-reset stall period emulating calibration; must be >= 1.

Ports:
- i_controller_clk  in  1  sole clock; all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_wb_cyc  in  1  bus cycle active.
- i_wb_stb  in  1  request strobe.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_addr  in  ADDR_BITS  word address.
- i_wb_data  in  DATA_WIDTH  write data.
- i_wb_sel  in  DATA_WIDTH/8  byte enables.
- i_aux  in  AUX_WIDTH  sideband tag.
- o_wb_stall  out  1  cannot accept a request this cycle.
- o_wb_ack  out  1  request completed.
- o_wb_data  out  DATA_WIDTH  read data, valid with ack.
- o_aux  out  AUX_WIDTH  tag of the completing request.
- o_calib_done  out  1  high once in ACTIVE.

Behaviour:
- Reset values: o_wb_stall=1, o_wb_ack=0, o_wb_data=0, o_aux=0, o_calib_done=0. Pending count and pipeline valid bits are cleared. RAM contents are not cleared.
- FSM INIT:
  - Counts INIT_CYCLES, stall=1, requests ignored.
  - When the count reaches INIT_CYCLES-1 -> ACTIVE.
- FSM ACTIVE:
  - Accept when i_wb_cyc & i_wb_stb & !o_wb_stall at the clock edge.
  - i_wb_cyc falling to 0 while pending != 0 -> FLUSH.
- FSM FLUSH:
  - Stall=1; all pipeline valid bits cleared; pending=0.
  - Returns to ACTIVE on the next cycle.
  - Flushed requests never ack.
  - Writes already accepted remain committed.
- Reset has priority from any state, including mid-operation; it returns the FSM to INIT.
- o_wb_stall is driven from registers only, with no combinational path from i_wb_stb. It is 1 when:
  - state != ACTIVE, or
  - pending == MAX_OUTSTANDING and no ack is being issued this cycle.
- Address handling:
  - RAM index = i_wb_addr[$clog2(DEPTH)-1:0].
  - Upper bits are ignored, so addresses alias and wrap modulo DEPTH.
- Write:
  - On accept, RAM bytes with i_wb_sel=1 are updated on the same edge.
  - sel=0 bytes are unchanged.
  - Write data is not returned: o_wb_data is 0 on write acks.
- Read:
  - Data is sampled from the RAM at the accept edge.
  - A write accepted on an earlier edge is visible; read-after-write ordering is preserved.
- Latency: a request accepted at edge N produces o_wb_ack=1 for exactly one cycle after edge N+LATENCY, with o_aux = i_aux captured at accept.
- Acks return in acceptance order. Back-to-back accepts give back-to-back acks.
- Pending counter: +1 on accept, -1 on ack, unchanged when both occur; it never exceeds MAX_OUTSTANDING.
- A strobe while stalled is ignored; the initiator must hold it.

Optional Feature:
- Macro: WB_RESP_STALL_INJECT_EN.
- Defined:
  - A 16-bit LFSR (taps 16,15,13,4, seed 16'hACE1 on reset) advances every cycle in ACTIVE.
  - When LFSR[1:0]==2'b00, o_wb_stall is additionally forced to 1 that cycle.
  - Ordering, latency and data are unaffected, since latency counts from acceptance.
- Undefined: no LFSR logic; stall follows the base rules only.

Decomposition:
- Package wb_ddr3_responder_pkg holds:
  - state enum {INIT, ACTIVE, FLUSH};
  - LFSR seed and taps constants;
  - the helper function for byte-lane count (DATA_WIDTH/8).
- One sub-module, wb_resp_delay_line: a LATENCY-deep shift register of {valid, data, aux} with a synchronous flush input.
- RAM and FSM stay in the top.

Test Plan:
- Reset, then idle -> stall=1 and calib_done=0 for exactly 64 cycles; stall=0 and calib_done=1 from cycle 65.
- Write addr 0x10, data 0x..0061, sel all-ones; then read addr 0x10 -> read ack 8 cycles after its accept, o_wb_data=0x..0061, o_aux echoes the read's tag.
- 6 back-to-back reads (stb held) -> stall rises after 4 accepts and drops when the first ack fires; 6 acks in order, each 8 cycles after its accept.
- Write 0xFFFF..FF to addr 3, then write 0x00..00 with sel=16'h0001 -> read returns 0xFFFF..FF00.
- Address 0x000403 with DEPTH=1024 -> aliases to index 3; returns the same data as addr 3.
- Drop cyc with 3 pending -> no further acks, one FLUSH stall cycle, then a new read acks normally. With WB_RESP_STALL_INJECT_EN: 1000 random requests all ack with correct data.
